// File: rtl/noise_pkg.sv
// Shared definitions for the noise burst scheduler: FSM state encodings,
// config register addresses and the power-on config values.
package noise_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_SEED = 2'd1;
  localparam state_t S_RUN  = 2'd2;
  localparam state_t S_DONE = 2'd3;

  localparam logic [1:0] A_PER_LO = 2'd0;
  localparam logic [1:0] A_PER_HI = 2'd1;
  localparam logic [1:0] A_LEN    = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;

  localparam logic [15:0] PERIOD_DEF = 16'h00FF;
  localparam logic [7:0]  LEN_DEF    = 8'h10;
  localparam logic [1:0]  CTRL_DEF   = 2'b01;

endpackage

// File: rtl/step_divider.sv
// Down-counting step divider: load sets the count, en decrements it until it
// reaches zero, and zero flags the terminal count.
module step_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && count != '0)
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/noise_sched.sv
// Noise burst scheduler: paces LFSR shifts and gates noise to audio_out.
// Define NOISE_SCHED_RESEED_EN to enable the SEED state and the lfsr_rst pulse.
module noise_sched
  import noise_pkg::*;
#(
  parameter int PERIOD_W = 16,  // at most 16: period register is two bytes
  parameter int LEN_W    = 8    // at most 8: length register is one byte
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_wr,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       trig,
  input  logic       stop,
  input  logic       noise_in,
  output logic       en_step,
  output logic       lfsr_rst,
  output logic       audio_out,
  output logic       busy,
  output logic       done
);

`ifdef NOISE_SCHED_RESEED_EN
  localparam logic RESEED_OK = 1'b1;
`else
  localparam logic RESEED_OK = 1'b0;
`endif

  state_t state, nxt;

  logic [15:0] cfg_period;
  logic [7:0]  cfg_len;
  logic [1:0]  cfg_ctrl;

  logic [PERIOD_W-1:0] act_period;
  logic [LEN_W-1:0]    act_len;
  logic                act_loop;
  logic [LEN_W-1:0]    step_cnt;

  logic run, reseed, abort, start, last_step, div_load, div_zero;
  logic [PERIOD_W-1:0] div_val;

  assign run       = (state == S_RUN);
  assign busy      = (state == S_SEED) || run;
  assign done      = (state == S_DONE);
  assign lfsr_rst  = RESEED_OK & (state == S_SEED);
  assign en_step   = run && div_zero;
  assign reseed    = RESEED_OK & cfg_ctrl[0];
  // stop only aborts an active burst, and then overrides a same-cycle trig
  assign abort     = stop && busy;
  assign start     = trig && !abort;
  assign last_step = en_step && (act_len != '0) && (step_cnt == act_len - LEN_W'(1));

  always_comb begin
    nxt = state;
    if (abort)
      nxt = S_IDLE;
    else if (start)
      nxt = reseed ? S_SEED : S_RUN;
    else begin
      case (state)
        S_SEED:  nxt = S_RUN;
        S_RUN:   if (last_step && !act_loop) nxt = S_DONE;
        S_DONE:  nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  // Divider is primed while entering RUN, so period 0 steps on the first RUN cycle
  assign div_load = en_step || ((nxt == S_RUN) && (!run || start));
  assign div_val  = start ? cfg_period[PERIOD_W-1:0] : act_period;

  step_divider #(.W(PERIOD_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .en       (run),
    .load_val (div_val),
    .zero     (div_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      step_cnt   <= '0;
      audio_out  <= 1'b0;
      cfg_period <= PERIOD_DEF;
      cfg_len    <= LEN_DEF;
      cfg_ctrl   <= CTRL_DEF & {1'b1, RESEED_OK};
    end else begin
      state     <= nxt;
      audio_out <= run & noise_in;
      if (start)
        step_cnt <= '0;
      else if (en_step)
        step_cnt <= last_step ? '0 : step_cnt + LEN_W'(1);
      if (cfg_wr) begin
        case (cfg_addr)
          A_PER_LO: cfg_period[7:0]  <= cfg_data;
          A_PER_HI: cfg_period[15:8] <= cfg_data;
          A_LEN:    cfg_len          <= cfg_data;
          default:  cfg_ctrl         <= {cfg_data[1], cfg_data[0] & RESEED_OK};
        endcase
      end
    end
  end

  // Active copies are taken from the pre-write config, so a same-cycle write lands on the next trig
  always_ff @(posedge clk) begin
    if (start) begin
      act_period <= cfg_period[PERIOD_W-1:0];
      act_len    <= cfg_len[LEN_W-1:0];
      act_loop   <= cfg_ctrl[1];
    end
  end

endmodule
